psram_arbiter: RTL and testbench

- Shares the single PSRAM controller port between two requesters: the RISCuin CPU data port (requester 0) and the external MCU port (requester 1, MCU_REQ/MCU_ACK).
- Arbitrates between them round-robin and latches the winner's command.
- Sequences the PSRAM controller through start/busy/done, returns read data, and completes a 4-phase req/ack handshake with the winner.
- Enforces a completion timeout so a hung PSRAM transfer cannot lock either requester out.

---
 rtl/psram_pkg.sv | 37 +++
 rtl/psram_arbiter_if.sv | 57 +++++
 rtl/sync2.sv | 32 +++
 rtl/psram_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_psram_arbiter.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM arbiter: FSM state encoding, requester
// IDs, default completion timeout and the round-robin grant decision.
package psram_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_ISSUE   = 3'd1;
    localparam state_t ST_WAIT    = 3'd2;
    localparam state_t ST_RESP    = 3'd3;
    localparam state_t ST_RELEASE = 3'd4;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_MCU = 1'b1;

    localparam int TIMEOUT_DEF = 1023;

    // The MCU port has no byte enables; its transfers are always full words.
    localparam logic [3:0] MCU_BE = 4'hF;

    // Pick a winner among the live requests. On a tie the requester that was
    // not served last wins; with a single request that requester wins.
    function automatic logic pick_grant(input logic cpu_req,
                                        input logic mcu_req,
                                        input logic last_grant);
        logic g;
        if (cpu_req && mcu_req) begin
            g = ~last_grant;
        end else if (mcu_req) begin
            g = REQ_MCU;
        end else begin
            g = REQ_CPU;
        end
        return g;
    endfunction

endpackage

// File: rtl/psram_arbiter_if.sv
// Bundles the CPU, MCU and PSRAM-controller signals of the arbiter.
// slave  = the arbiter's view, master = the surrounding system's view.
interface psram_arbiter_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 32
);
    // CPU data port
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [3:0]        cpu_be;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    // External MCU port
    logic              mcu_req;
    logic              mcu_we;
    logic [ADDR_W-1:0] mcu_addr;
    logic [DATA_W-1:0] mcu_wdata;
    logic              mcu_ack;
    logic [DATA_W-1:0] mcu_rdata;

    // PSRAM controller command/response
    logic              mem_start;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_busy;
    logic              mem_done;
    logic [DATA_W-1:0] mem_rdata;

    // Status
    logic              err;
    logic              owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        output cpu_ack, cpu_rdata,
        input  mcu_req, mcu_we, mcu_addr, mcu_wdata,
        output mcu_ack, mcu_rdata,
        output mem_start, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_busy, mem_done, mem_rdata,
        output err, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
        input  cpu_ack, cpu_rdata,
        output mcu_req, mcu_we, mcu_addr, mcu_wdata,
        input  mcu_ack, mcu_rdata,
        input  mem_start, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_busy, mem_done, mem_rdata,
        input  err, owner
    );
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Synchronous active-low reset clears both stages.
module sync2 (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic ff1_q, ff1_d;
    logic ff2_q, ff2_d;

    // Next-state of the two synchronizer stages.
    always_comb begin
        ff1_d = d;
        ff2_d = ff1_q;
    end

    // Synchronizer stage registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
        end else begin
            ff1_q <= ff1_d;
            ff2_q <= ff2_d;
        end
    end

    assign q = ff2_q;

endmodule

// File: rtl/psram_arbiter.sv
// Round-robin arbiter sharing one PSRAM controller port between the CPU data
// port and the external MCU port. Latches the winner's command, sequences the
// controller (start/busy/done), returns read data with a 4-phase req/ack
// handshake and aborts a transfer that never completes.
module psram_arbiter
    import psram_pkg::*;
#(
    parameter int ADDR_W   = 23,
    parameter int DATA_W   = 32,
    parameter int TIMEOUT  = TIMEOUT_DEF,
    parameter int SYNC_MCU = 1
) (
    input  logic           clk,
    input  logic           rstn,
    psram_arbiter_if.slave bus
);

    localparam logic [9:0] TMO_LIM = 10'(TIMEOUT);

    // Combinational helpers
    logic       mreq_s;
    logic       grant_s;
    logic       owner_req_s;
    logic       start_s;
    logic [9:0] tmo_inc_s;

    // State and registered outputs
    state_t            state_q,     state_d;
    logic              rr_last_q,   rr_last_d;
    logic              owner_q,     owner_d;
    logic              cpu_ack_q,   cpu_ack_d;
    logic              mcu_ack_q,   mcu_ack_d;
    logic              err_q,       err_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] mcu_rdata_q, mcu_rdata_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q,    mem_be_d;
    logic [9:0]        tmo_q,       tmo_d;

    // The MCU request comes from another clock domain unless told otherwise.
    if (SYNC_MCU != 0) begin : g_sync
        sync2 u_sync (
            .clk  (clk),
            .rstn (rstn),
            .d    (bus.mcu_req),
            .q    (mreq_s)
        );
    end else begin : g_nosync
        assign mreq_s = bus.mcu_req;
    end

    // Arbitration decision, owner's live request and timeout increment.
    always_comb begin
        grant_s     = pick_grant(bus.cpu_req, mreq_s, rr_last_q);
        owner_req_s = (owner_q == REQ_MCU) ? mreq_s : bus.cpu_req;
        tmo_inc_s   = tmo_q + 10'd1;
    end

    // The start strobe must fall in the very first non-busy cycle of ISSUE,
    // so it is decoded from the state flop and the live busy input.
    assign start_s = (state_q == ST_ISSUE) && !bus.mem_busy;

    // Transfer sequencer: arbitrate, issue, wait for completion, handshake.
    always_comb begin
        state_d     = state_q;
        rr_last_d   = rr_last_q;
        owner_d     = owner_q;
        cpu_ack_d   = cpu_ack_q;
        mcu_ack_d   = mcu_ack_q;
        err_d       = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        mcu_rdata_d = mcu_rdata_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        tmo_d       = tmo_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_req || mreq_s) begin
                    owner_d = grant_s;
                    state_d = ST_ISSUE;
                    if (grant_s == REQ_MCU) begin
                        mem_we_d    = bus.mcu_we;
                        mem_addr_d  = bus.mcu_addr;
                        mem_wdata_d = bus.mcu_wdata;
                        mem_be_d    = MCU_BE;
                    end else begin
                        mem_we_d    = bus.cpu_we;
                        mem_addr_d  = bus.cpu_addr;
                        mem_wdata_d = bus.cpu_wdata;
                        mem_be_d    = bus.cpu_be;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ISSUE: begin
                if (start_s) begin
                    // Counter holds the number of cycles elapsed since the
                    // mem_start cycle, so it equals TIMEOUT when err is raised.
                    tmo_d   = 10'd1;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end

            ST_WAIT: begin
                if (bus.mem_done) begin
                    // Completion beats a coincident timeout.
                    if (owner_q == REQ_MCU) begin
                        mcu_rdata_d = bus.mem_rdata;
                        mcu_ack_d   = 1'b1;
                    end else begin
                        cpu_rdata_d = bus.mem_rdata;
                        cpu_ack_d   = 1'b1;
                    end
                    state_d = ST_RESP;
                end else if (tmo_inc_s == TMO_LIM) begin
                    err_d = 1'b1;
                    tmo_d = tmo_inc_s;
                    if (owner_q == REQ_MCU) begin
                        mcu_rdata_d = {DATA_W{1'b0}};
                        mcu_ack_d   = 1'b1;
                    end else begin
                        cpu_rdata_d = {DATA_W{1'b0}};
                        cpu_ack_d   = 1'b1;
                    end
                    state_d = ST_RESP;
                end else begin
                    tmo_d   = tmo_inc_s;
                    state_d = ST_WAIT;
                end
            end

            ST_RESP: begin
                if (owner_req_s) begin
                    state_d = ST_RESP;
                end else begin
                    cpu_ack_d = 1'b0;
                    mcu_ack_d = 1'b0;
                    state_d   = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                // The idle cycle here lets a waiting requester win next.
                rr_last_d = owner_q;
                state_d   = ST_IDLE;
            end

            default: begin
                cpu_ack_d = 1'b0;
                mcu_ack_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            rr_last_q   <= REQ_MCU;
            owner_q     <= REQ_CPU;
            cpu_ack_q   <= 1'b0;
            mcu_ack_q   <= 1'b0;
            err_q       <= 1'b0;
            cpu_rdata_q <= {DATA_W{1'b0}};
            mcu_rdata_q <= {DATA_W{1'b0}};
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            mem_be_q    <= 4'h0;
            tmo_q       <= 10'd0;
        end else begin
            state_q     <= state_d;
            rr_last_q   <= rr_last_d;
            owner_q     <= owner_d;
            cpu_ack_q   <= cpu_ack_d;
            mcu_ack_q   <= mcu_ack_d;
            err_q       <= err_d;
            cpu_rdata_q <= cpu_rdata_d;
            mcu_rdata_q <= mcu_rdata_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            tmo_q       <= tmo_d;
        end
    end

    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.mcu_ack   = mcu_ack_q;
    assign bus.mcu_rdata = mcu_rdata_q;
    assign bus.mem_start = start_s;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.err       = err_q;
    assign bus.owner     = owner_q;

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed self-checking bench for psram_arbiter.
module tb_psram_arbiter;

    localparam int AW = 23;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    psram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    psram_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .TIMEOUT  (1023),
        .SYNC_MCU (1)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int ms_cnt   = 0;
    int err_cnt  = 0;
    int ovl_cnt  = 0;
    int ms_base;
    int err_base;
    logic exp_own [3];

    // Event counters: start strobes, error pulses, simultaneous acks.
    always @(posedge clk) begin
        if (bus.mem_start === 1'b1) ms_cnt <= ms_cnt + 1;
        if (bus.err === 1'b1) err_cnt <= err_cnt + 1;
        if (bus.cpu_ack === 1'b1 && bus.mcu_ack === 1'b1) ovl_cnt <= ovl_cnt + 1;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rstn = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0;
        bus.cpu_wdata = '0; bus.cpu_be = 4'h0;
        bus.mcu_req = 1'b0; bus.mcu_we = 1'b0; bus.mcu_addr = '0; bus.mcu_wdata = '0;
        bus.mem_busy = 1'b0; bus.mem_done = 1'b0; bus.mem_rdata = '0;
        exp_own[0] = 1'b0; exp_own[1] = 1'b1; exp_own[2] = 1'b0;

        // ---------------- reset state ----------------
        tick(3);
        chk("rst_cpu_ack",   32'(bus.cpu_ack),   32'd0);
        chk("rst_mcu_ack",   32'(bus.mcu_ack),   32'd0);
        chk("rst_err",       32'(bus.err),       32'd0);
        chk("rst_owner",     32'(bus.owner),     32'd0);
        chk("rst_mem_start", 32'(bus.mem_start), 32'd0);
        chk("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        chk("rst_cpu_rdata", bus.cpu_rdata,      32'd0);
        rstn = 1'b1;
        tick(1);

        // ---------------- T1: CPU read, done 5 cycles after start ----------------
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 23'h000100;
        bus.cpu_be = 4'hF; bus.cpu_wdata = 32'h0BAD0BAD;
        ms_base = ms_cnt;
        tick(1);
        chk("t1_start", 32'(bus.mem_start), 32'd1);
        chk("t1_we",    32'(bus.mem_we),    32'd0);
        chk("t1_addr",  32'(bus.mem_addr),  32'h000100);
        chk("t1_owner", 32'(bus.owner),     32'd0);
        tick(1);
        chk("t1_start_low", 32'(bus.mem_start), 32'd0);
        tick(4);
        chk("t1_ack_early", 32'(bus.cpu_ack), 32'd0);
        bus.mem_done = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        tick(1);
        bus.mem_done = 1'b0; bus.mem_rdata = 32'h0;
        chk("t1_ack",     32'(bus.cpu_ack), 32'd1);
        chk("t1_rdata",   bus.cpu_rdata,    32'hDEADBEEF);
        chk("t1_mcu_ack", 32'(bus.mcu_ack), 32'd0);
        tick(1);
        chk("t1_ack_hold", 32'(bus.cpu_ack), 32'd1);
        bus.cpu_req = 1'b0;
        tick(1);
        chk("t1_ack_drop", 32'(bus.cpu_ack), 32'd0);
        chk("t1_one_start", 32'(ms_cnt - ms_base), 32'd1);
        tick(2);

        // ---------------- T2: MCU write through the synchronizer ----------------
        bus.mcu_req = 1'b1; bus.mcu_we = 1'b1;
        bus.mcu_addr = 23'h7FFFFC; bus.mcu_wdata = 32'h12345678;
        tick(1);
        chk("t2_no_start_c1", 32'(bus.mem_start), 32'd0);
        tick(1);
        chk("t2_no_start_c2", 32'(bus.mem_start), 32'd0);
        tick(1);
        chk("t2_start", 32'(bus.mem_start), 32'd1);
        chk("t2_be",    32'(bus.mem_be),    32'hF);
        chk("t2_we",    32'(bus.mem_we),    32'd1);
        chk("t2_addr",  32'(bus.mem_addr),  32'h7FFFFC);
        chk("t2_wdata", bus.mem_wdata,      32'h12345678);
        chk("t2_owner", 32'(bus.owner),     32'd1);
        tick(1);
        chk("t2_addr_hold", 32'(bus.mem_addr), 32'h7FFFFC);
        bus.mem_done = 1'b1; bus.mem_rdata = 32'hA5A5A5A5;
        tick(1);
        bus.mem_done = 1'b0;
        chk("t2_mcu_ack",   32'(bus.mcu_ack), 32'd1);
        chk("t2_cpu_ack",   32'(bus.cpu_ack), 32'd0);
        chk("t2_mcu_rdata", bus.mcu_rdata,    32'hA5A5A5A5);
        chk("t2_cpu_rdata_keep", bus.cpu_rdata, 32'hDEADBEEF);
        bus.mcu_req = 1'b0;
        tick(2);
        chk("t2_ack_hold", 32'(bus.mcu_ack), 32'd1);
        tick(1);
        chk("t2_ack_drop", 32'(bus.mcu_ack), 32'd0);
        chk("t2_owner_keep", 32'(bus.owner), 32'd1);
        tick(2);

        // ---------------- T3: contention, alternating grants ----------------
        bus.mcu_req = 1'b1; bus.mcu_we = 1'b0; bus.mcu_addr = 23'h002000;
        bus.cpu_we = 1'b0; bus.cpu_addr = 23'h001000;
        tick(2);
        bus.cpu_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 20 && bus.mem_start !== 1'b1; i++) tick(1);
            chk("t3_start", 32'(bus.mem_start), 32'd1);
            chk("t3_owner", 32'(bus.owner), 32'(exp_own[k]));
            if (k == 2) bus.mcu_req = 1'b0;
            tick(1);
            bus.mem_done = 1'b1; bus.mem_rdata = 32'hC0DE0000 + 32'(k);
            tick(1);
            bus.mem_done = 1'b0;
            if (exp_own[k] == 1'b0) begin
                chk("t3_cpu_ack",   32'(bus.cpu_ack), 32'd1);
                chk("t3_cpu_rdata", bus.cpu_rdata,    32'hC0DE0000 + 32'(k));
                bus.cpu_req = 1'b0;
            end else begin
                chk("t3_mcu_ack",   32'(bus.mcu_ack), 32'd1);
                chk("t3_mcu_rdata", bus.mcu_rdata,    32'hC0DE0000 + 32'(k));
                bus.mcu_req = 1'b0;
            end
            for (int i = 0; i < 10 && (bus.cpu_ack | bus.mcu_ack) === 1'b1; i++) tick(1);
            chk("t3_ack_low", 32'(bus.cpu_ack | bus.mcu_ack), 32'd0);
            if (k < 2) begin
                if (exp_own[k] == 1'b0) bus.cpu_req = 1'b1;
                else bus.mcu_req = 1'b1;
            end
        end
        tick(4);

        // ---------------- T4: controller busy for 20 cycles after grant ----------------
        bus.mem_busy = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 23'h0055AA;
        bus.cpu_wdata = 32'h0F0F0F0F; bus.cpu_be = 4'b0011;
        ms_base = ms_cnt;
        tick(1);
        chk("t4_no_start_c1", 32'(bus.mem_start), 32'd0);
        chk("t4_be",          32'(bus.mem_be),    32'h3);
        tick(19);
        chk("t4_no_start_c20", 32'(bus.mem_start), 32'd0);
        chk("t4_no_starts",    32'(ms_cnt - ms_base), 32'd0);
        tick(1);
        bus.mem_busy = 1'b0;
        #1;
        chk("t4_start", 32'(bus.mem_start), 32'd1);
        tick(1);
        chk("t4_start_gone", 32'(bus.mem_start), 32'd0);
        chk("t4_one_start",  32'(ms_cnt - ms_base), 32'd1);
        bus.mem_done = 1'b1; bus.mem_rdata = 32'h600DF00D;
        tick(1);
        bus.mem_done = 1'b0;
        chk("t4_ack",   32'(bus.cpu_ack), 32'd1);
        chk("t4_rdata", bus.cpu_rdata,    32'h600DF00D);
        bus.cpu_req = 1'b0;
        tick(3);
        chk("t4_still_one_start", 32'(ms_cnt - ms_base), 32'd1);

        // ---------------- T5: completion timeout ----------------
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 23'h0003FF; bus.cpu_be = 4'hF;
        err_base = err_cnt;
        tick(1);
        chk("t5_start", 32'(bus.mem_start), 32'd1);
        tick(1022);
        chk("t5_err_early", 32'(bus.err),     32'd0);
        chk("t5_ack_early", 32'(bus.cpu_ack), 32'd0);
        tick(1);
        chk("t5_err",   32'(bus.err),     32'd1);
        chk("t5_ack",   32'(bus.cpu_ack), 32'd1);
        chk("t5_rdata", bus.cpu_rdata,    32'd0);
        tick(1);
        chk("t5_err_pulse", 32'(bus.err), 32'd0);
        chk("t5_err_count", 32'(err_cnt - err_base), 32'd1);
        bus.cpu_req = 1'b0;
        tick(1);
        chk("t5_ack_drop", 32'(bus.cpu_ack), 32'd0);
        tick(2);
        bus.cpu_req = 1'b1; bus.cpu_addr = 23'h000400;
        tick(1);
        chk("t5_next_start", 32'(bus.mem_start), 32'd1);
        tick(1);
        bus.mem_done = 1'b1; bus.mem_rdata = 32'h11223344;
        tick(1);
        bus.mem_done = 1'b0;
        chk("t5_next_ack",   32'(bus.cpu_ack), 32'd1);
        chk("t5_next_rdata", bus.cpu_rdata,    32'h11223344);
        chk("t5_next_err",   32'(bus.err),     32'd0);
        bus.cpu_req = 1'b0;
        tick(3);

        // ---------------- T6: reset during WAIT, late mem_done ----------------
        bus.cpu_req = 1'b1; bus.cpu_addr = 23'h000800;
        err_base = err_cnt;
        tick(1);
        chk("t6_start", 32'(bus.mem_start), 32'd1);
        tick(1);
        rstn = 1'b0; bus.cpu_req = 1'b0;
        tick(1);
        rstn = 1'b1;
        chk("t6_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        tick(1);
        bus.mem_done = 1'b1; bus.mem_rdata = 32'hBADBAD00;
        tick(1);
        bus.mem_done = 1'b0;
        chk("t6_no_cpu_ack",  32'(bus.cpu_ack),   32'd0);
        chk("t6_no_mcu_ack",  32'(bus.mcu_ack),   32'd0);
        chk("t6_no_err",      32'(bus.err),       32'd0);
        chk("t6_rdata_clear", bus.cpu_rdata,      32'd0);
        chk("t6_no_start",    32'(bus.mem_start), 32'd0);
        tick(2);
        chk("t6_err_count", 32'(err_cnt - err_base), 32'd0);
        bus.cpu_req = 1'b1; bus.cpu_addr = 23'h000804;
        tick(1);
        chk("t6_next_start", 32'(bus.mem_start), 32'd1);
        chk("t6_next_addr",  32'(bus.mem_addr),  32'h000804);
        tick(1);
        bus.mem_done = 1'b1; bus.mem_rdata = 32'h0C0FFEE0;
        tick(1);
        bus.mem_done = 1'b0;
        chk("t6_next_ack",   32'(bus.cpu_ack), 32'd1);
        chk("t6_next_rdata", bus.cpu_rdata,    32'h0C0FFEE0);
        bus.cpu_req = 1'b0;
        tick(2);
        chk("t6_next_ack_drop", 32'(bus.cpu_ack), 32'd0);

        // ---------------- whole run: acks never overlapped ----------------
        chk("ack_overlap", 32'(ovl_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
